// File: rtl/decoder_nx_seq.sv
// rtl/decoder_nx_seq.sv - registered N-to-2^N decoder with one-hot, thermometer, active-low and scan modes
module decoder_nx_seq #(
  parameter int N         = 2,
  parameter bit SCAN_WRAP = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic                in_valid,
  input  logic [N-1:0]        in_a,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [(1<<N)-1:0]   out_d,
  output logic                busy
);

  localparam int W = 1 << N;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t         state_q, state_d;
  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   out_d_q, out_d_d;
  logic [N-1:0]   cnt_q, cnt_d;
  logic [N-1:0]   beats_q, beats_d;
  logic           accept, xfer, last_beat;

  function automatic logic [W-1:0] onehot(input logic [N-1:0] a);
    onehot = W'(1) << a;
  endfunction

  // Bits 0..a set; for a = W-1 the shifted one falls off and the subtract yields all ones.
  function automatic logic [W-1:0] thermo(input logic [N-1:0] a);
    logic [W-1:0] sh;
    sh     = (W'(1) << a) << 1;
    thermo = sh - W'(1);
  endfunction

  assign in_ready  = en && (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  // A ready pulse while frozen is not a transfer.
  assign xfer      = en && out_valid_q && out_ready;
  // Wrapping scans count delivered beats; non-wrapping scans stop at the top code.
  assign last_beat = SCAN_WRAP ? (beats_q == N'(W - 1)) : (cnt_q == N'(W - 1));

  assign out_valid = out_valid_q;
  assign out_d     = out_d_q;
  assign busy      = (state_q == SCAN);

  // Next-state and output-register update for the IDLE/SCAN controller.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_d_d     = out_d_q;
    cnt_d       = cnt_q;
    beats_d     = beats_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          out_valid_d = 1'b1;
          case (mode)
            2'b00: out_d_d = onehot(in_a);
            2'b01: out_d_d = thermo(in_a);
            2'b10: out_d_d = ~onehot(in_a);
            default: begin
              out_d_d = onehot(in_a);
              cnt_d   = in_a;
              beats_d = '0;
              state_d = SCAN;
            end
          endcase
        end else if (xfer) begin
          out_valid_d = 1'b0;
        end
      end
      SCAN: begin
        if (xfer) begin
          if (last_beat) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end else begin
            cnt_d   = cnt_q + N'(1);
            beats_d = beats_q + N'(1);
            out_d_d = onehot(cnt_q + N'(1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_d_q     <= '0;
      cnt_q       <= '0;
      beats_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_d_q     <= out_d_d;
      cnt_q       <= cnt_d;
      beats_q     <= beats_d;
    end
  end

endmodule

// File: tb/tb_decoder_nx_seq.sv
// tb/tb_decoder_nx_seq.sv - directed self-checking bench for decoder_nx_seq
module tb_decoder_nx_seq;

  logic       clk = 1'b0;
  logic       rst, en, in_valid, out_ready;
  logic [1:0] mode;
  logic [1:0] in_a;

  logic       w_in_ready, w_out_valid, w_busy;
  logic [3:0] w_out_d;
  logic       nw_in_ready, nw_out_valid, nw_busy;
  logic [3:0] nw_out_d;
  logic       n1_in_ready, n1_out_valid, n1_busy;
  logic [1:0] n1_out_d;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decoder_nx_seq #(.N(2), .SCAN_WRAP(1'b1)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid), .in_a(in_a),
    .in_ready(w_in_ready), .out_valid(w_out_valid), .out_ready(out_ready),
    .out_d(w_out_d), .busy(w_busy)
  );

  decoder_nx_seq #(.N(2), .SCAN_WRAP(1'b0)) u_nowrap (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid), .in_a(in_a),
    .in_ready(nw_in_ready), .out_valid(nw_out_valid), .out_ready(out_ready),
    .out_d(nw_out_d), .busy(nw_busy)
  );

  decoder_nx_seq #(.N(1), .SCAN_WRAP(1'b1)) u_n1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid), .in_a(in_a[0]),
    .in_ready(n1_in_ready), .out_valid(n1_out_valid), .out_ready(out_ready),
    .out_d(n1_out_d), .busy(n1_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] scan_exp [5];
    logic [1:0] n1_exp   [3];
    logic       rdy_seq  [5];
    scan_exp = '{4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0010};
    n1_exp   = '{2'b01, 2'b10, 2'b10};
    rdy_seq  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    rst = 1'b1; en = 1'b1; mode = 2'b00; in_valid = 1'b0; in_a = 2'd0; out_ready = 1'b1;
    #1;
    chk("rst_valid", 32'(w_out_valid), 32'd0);
    chk("rst_d", 32'(w_out_d), 32'd0);
    chk("rst_busy", 32'(w_busy), 32'd0);
    chk("rst_n1_d", 32'(n1_out_d), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // one-hot back to back
    in_valid = 1'b1; mode = 2'b00;
    for (int a = 0; a < 4; a++) begin
      in_a = 2'(a);
      tick();
      chk("onehot_d", 32'(w_out_d), 32'(4'b0001 << a));
      chk("onehot_v", 32'(w_out_valid), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("drain_v", 32'(w_out_valid), 32'd0);
    chk("drain_hold_d", 32'(w_out_d), 32'h8);

    // thermometer and active-low
    in_valid = 1'b1; mode = 2'b01; in_a = 2'd2;
    tick();
    chk("thermo2", 32'(w_out_d), 32'h7);
    mode = 2'b10; in_a = 2'd1;
    tick();
    chk("actlow1", 32'(w_out_d), 32'hD);
    mode = 2'b01; in_a = 2'd3;
    tick();
    chk("thermo3", 32'(w_out_d), 32'hF);
    in_valid = 1'b0;
    tick();

    // backpressure
    mode = 2'b00; in_a = 2'd3; in_valid = 1'b1;
    tick();
    chk("bp_first", 32'(w_out_d), 32'h8);
    in_a = 2'd0; out_ready = 1'b0;
    #1;
    chk("bp_ready0", 32'(w_in_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_d", 32'(w_out_d), 32'h8);
      chk("bp_hold_v", 32'(w_out_valid), 32'd1);
      chk("bp_hold_rdy", 32'(w_in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", 32'(w_in_ready), 32'd1);
    tick();
    chk("bp_swap_d", 32'(w_out_d), 32'h1);
    chk("bp_swap_v", 32'(w_out_valid), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("bp_end_v", 32'(w_out_valid), 32'd0);

    // scan with wrap, mode changes ignored mid-scan; also N=1 and no-wrap side by side
    do_reset();
    mode = 2'b11; in_a = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; mode = 2'b00;
    for (int k = 0; k < 5; k++) begin
      out_ready = rdy_seq[k];
      #1;
      chk("scan_d", 32'(w_out_d), 32'(scan_exp[k]));
      chk("scan_busy", 32'(w_busy), 32'd1);
      chk("scan_rdy", 32'(w_in_ready), 32'd0);
      if (k < 2) chk("nw_scan_d", 32'(nw_out_d), 32'(scan_exp[k]));
      if (k < 3) chk("n1_scan_d", 32'(n1_out_d), 32'(n1_exp[k]));
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("scan_end_busy", 32'(w_busy), 32'd0);
    chk("scan_end_v", 32'(w_out_valid), 32'd0);
    chk("scan_end_rdy", 32'(w_in_ready), 32'd1);
    chk("nw_end_busy", 32'(nw_busy), 32'd0);
    chk("n1_end_busy", 32'(n1_busy), 32'd0);
    chk("n1_end_v", 32'(n1_out_valid), 32'd0);

    // no-wrap scan with a freeze mid-scan
    do_reset();
    mode = 2'b11; in_a = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("nw_beat1", 32'(nw_out_d), 32'h4);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("nw_frz_d", 32'(nw_out_d), 32'h4);
      chk("nw_frz_v", 32'(nw_out_valid), 32'd1);
      chk("nw_frz_busy", 32'(nw_busy), 32'd1);
    end
    en = 1'b1;
    tick();
    chk("nw_beat2", 32'(nw_out_d), 32'h8);
    chk("nw_beat2_busy", 32'(nw_busy), 32'd1);
    tick();
    chk("nw_done_v", 32'(nw_out_valid), 32'd0);
    chk("nw_done_busy", 32'(nw_busy), 32'd0);
    chk("nw_done_d", 32'(nw_out_d), 32'h8);

    // asynchronous reset during scan beat 2
    do_reset();
    mode = 2'b11; in_a = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("ar_beat2", 32'(w_out_d), 32'h8);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_v", 32'(w_out_valid), 32'd0);
    chk("ar_d", 32'(w_out_d), 32'd0);
    chk("ar_busy", 32'(w_busy), 32'd0);
    tick();
    rst = 1'b0;
    mode = 2'b00; in_a = 2'd1; in_valid = 1'b1;
    tick();
    chk("ar_after", 32'(w_out_d), 32'h2);
    chk("ar_after_busy", 32'(w_busy), 32'd0);
    in_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
